// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw pins in, debounced levels, change strobe and IRQ handshake out.
// The debouncer side uses the slave modport; the pin/processor side uses the master modport.
interface switch_debouncer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] SW_RAW;
  logic [WIDTH-1:0] SWITCHES;
  logic             SW_CHANGED;
  logic [WIDTH-1:0] SW_CHANGE_MASK;
  logic             SW_IRQ;
  logic             SW_IRQ_ACK;

  modport master (
    output SW_RAW,
    output SW_IRQ_ACK,
    input  SWITCHES,
    input  SW_CHANGED,
    input  SW_CHANGE_MASK,
    input  SW_IRQ
  );

  modport slave (
    input  SW_RAW,
    input  SW_IRQ_ACK,
    output SWITCHES,
    output SW_CHANGED,
    output SW_CHANGE_MASK,
    output SW_IRQ
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit 2-flop sync + stability counter; a level is accepted DEBOUNCE_CYCLES+1 edges after it settles.
// No backpressure: outputs update every cycle, IRQ stays sticky until acknowledged without a new change.
module switch_debouncer #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input logic               CLK,
  input logic               RESET,
  switch_debouncer_if.slave sw
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } irq_state_t;

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     switches;
  logic [WIDTH-1:0]     change_mask;
  logic [WIDTH-1:0]     accept;
  logic                 changed;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  irq_state_t           irq_state;
  irq_state_t           irq_state_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw.SW_RAW;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the edge where it has already differed for DEBOUNCE_CYCLES-1 counted cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != switches[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      switches    <= '0;
      change_mask <= '0;
      changed     <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == switches[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
      switches    <= switches ^ accept;
      change_mask <= accept;
      changed     <= |accept;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_state <= IDLE;
    end else begin
      irq_state <= irq_state_nxt;
    end
  end

  // A change in the same cycle as the acknowledge keeps the request pending.
  always_comb begin
    irq_state_nxt = irq_state;
    case (irq_state)
      IDLE:    if (|accept) irq_state_nxt = PENDING;
      PENDING: if (sw.SW_IRQ_ACK && !(|accept)) irq_state_nxt = IDLE;
    endcase
  end

  assign sw.SWITCHES       = switches;
  assign sw.SW_CHANGE_MASK = change_mask;
  assign sw.SW_CHANGED     = changed;
  assign sw.SW_IRQ         = (irq_state == PENDING);

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboarded bench for switch_debouncer with DEBOUNCE_CYCLES=4: expected change events are
// queued at drive time and matched against every SW_CHANGED pulse.
module tb_switch_debouncer;

  localparam int W = 16;
  localparam int D = 4;

  typedef struct {
    int          cyc;
    logic [15:0] mask;
    logic [15:0] sw;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k;
  exp_t sb [$];

  switch_debouncer_if #(.WIDTH(W)) sw_if ();

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(3)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .sw   (sw_if)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Accept edge is DEBOUNCE_CYCLES+1 edges after the first sampling edge.
  task automatic expect_change(input int drive_cyc, input logic [15:0] mask, input logic [15:0] swv);
    exp_t e;
    e.cyc  = drive_cyc + 1 + D + 1;
    e.mask = mask;
    e.sw   = swv;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (sw_if.SW_CHANGED === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_change", {16'h0, sw_if.SW_CHANGE_MASK}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_cycle", cyc, e.cyc);
        chk("sb_mask", {16'h0, sw_if.SW_CHANGE_MASK}, {16'h0, e.mask});
        chk("sb_switches", {16'h0, sw_if.SWITCHES}, {16'h0, e.sw});
      end
    end else begin
      chk("mask_idle_zero", {16'h0, sw_if.SW_CHANGE_MASK}, 32'h0);
    end
  end

  initial begin
    RESET            = 1'b1;
    sw_if.SW_RAW     = '0;
    sw_if.SW_IRQ_ACK = 1'b0;
    #3;
    chk("rst_switches", {16'h0, sw_if.SWITCHES}, 32'h0);
    chk("rst_changed", {31'h0, sw_if.SW_CHANGED}, 32'h0);
    chk("rst_irq", {31'h0, sw_if.SW_IRQ}, 32'h0);
    tick(3);
    RESET = 1'b0;

    // 1: quiet input
    tick(10);
    chk("t1_switches", {16'h0, sw_if.SWITCHES}, 32'h0);
    chk("t1_irq", {31'h0, sw_if.SW_IRQ}, 32'h0);

    // 2: single bit, exact latency
    k = cyc;
    sw_if.SW_RAW = 16'h0001;
    expect_change(k, 16'h0001, 16'h0001);
    tick(5);
    chk("t2_before_switches", {16'h0, sw_if.SWITCHES}, 32'h0);
    chk("t2_before_irq", {31'h0, sw_if.SW_IRQ}, 32'h0);
    tick(1);
    chk("t2_switches", {16'h0, sw_if.SWITCHES}, 32'h0001);
    chk("t2_changed", {31'h0, sw_if.SW_CHANGED}, 32'h1);
    chk("t2_irq", {31'h0, sw_if.SW_IRQ}, 32'h1);
    tick(1);
    chk("t2_changed_once", {31'h0, sw_if.SW_CHANGED}, 32'h0);
    chk("t2_irq_sticky", {31'h0, sw_if.SW_IRQ}, 32'h1);
    sw_if.SW_IRQ_ACK = 1'b1;
    tick(1);
    sw_if.SW_IRQ_ACK = 1'b0;
    chk("t2_irq_ack", {31'h0, sw_if.SW_IRQ}, 32'h0);
    sw_if.SW_IRQ_ACK = 1'b1;
    tick(1);
    sw_if.SW_IRQ_ACK = 1'b0;
    chk("t2_ack_idle", {31'h0, sw_if.SW_IRQ}, 32'h0);

    // 3: 3-cycle glitch rejected, 4-cycle pulse accepted and released
    sw_if.SW_RAW = 16'h0009;
    tick(3);
    sw_if.SW_RAW = 16'h0001;
    tick(10);
    chk("t3_glitch_switches", {16'h0, sw_if.SWITCHES}, 32'h0001);
    chk("t3_glitch_irq", {31'h0, sw_if.SW_IRQ}, 32'h0);
    k = cyc;
    sw_if.SW_RAW = 16'h0009;
    expect_change(k, 16'h0008, 16'h0009);
    tick(4);
    k = cyc;
    sw_if.SW_RAW = 16'h0001;
    expect_change(k, 16'h0008, 16'h0001);
    tick(2);
    chk("t3_pulse_high", {16'h0, sw_if.SWITCHES}, 32'h0009);
    chk("t3_pulse_irq", {31'h0, sw_if.SW_IRQ}, 32'h1);
    tick(4);
    chk("t3_pulse_low", {16'h0, sw_if.SWITCHES}, 32'h0001);
    sw_if.SW_IRQ_ACK = 1'b1;
    tick(1);
    sw_if.SW_IRQ_ACK = 1'b0;

    // 4: many bits accepted together
    k = cyc;
    sw_if.SW_RAW = 16'h0000;
    expect_change(k, 16'h0001, 16'h0000);
    tick(8);
    k = cyc;
    sw_if.SW_RAW = 16'hA5C3;
    expect_change(k, 16'hA5C3, 16'hA5C3);
    tick(6);
    chk("t4_switches", {16'h0, sw_if.SWITCHES}, 32'hA5C3);
    chk("t4_mask", {16'h0, sw_if.SW_CHANGE_MASK}, 32'hA5C3);
    chk("t4_irq", {31'h0, sw_if.SW_IRQ}, 32'h1);

    // 5: ack collides with a new change on bit 15
    k = cyc;
    sw_if.SW_RAW = 16'h25C3;
    expect_change(k, 16'h8000, 16'h25C3);
    tick(5);
    sw_if.SW_IRQ_ACK = 1'b1;
    tick(1);
    sw_if.SW_IRQ_ACK = 1'b0;
    chk("t5_collide_changed", {31'h0, sw_if.SW_CHANGED}, 32'h1);
    chk("t5_collide_irq", {31'h0, sw_if.SW_IRQ}, 32'h1);
    tick(2);
    chk("t5_still_pending", {31'h0, sw_if.SW_IRQ}, 32'h1);
    sw_if.SW_IRQ_ACK = 1'b1;
    tick(1);
    sw_if.SW_IRQ_ACK = 1'b0;
    chk("t5_ack_clears", {31'h0, sw_if.SW_IRQ}, 32'h0);

    // 6: reset mid-count, then power-up style acceptance
    k = cyc;
    sw_if.SW_RAW = 16'hFFFF;
    tick(4);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_async_switches", {16'h0, sw_if.SWITCHES}, 32'h0);
    chk("t6_async_irq", {31'h0, sw_if.SW_IRQ}, 32'h0);
    tick(2);
    RESET = 1'b0;
    k = cyc;
    expect_change(k, 16'hFFFF, 16'hFFFF);
    tick(5);
    chk("t6_before_switches", {16'h0, sw_if.SWITCHES}, 32'h0);
    tick(1);
    chk("t6_switches", {16'h0, sw_if.SWITCHES}, 32'hFFFF);
    chk("t6_changed", {31'h0, sw_if.SW_CHANGED}, 32'h1);
    chk("t6_irq", {31'h0, sw_if.SW_IRQ}, 32'h1);

    tick(3);
    chk("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
